serial_to_parallel: RTL

- Receive-side counterpart of the audio serial transmitter: deserialises a 32-bit-per-frame audio stream (left 16 bits then right 16 bits, MSB first) back into parallel samples.
- Runs on the single system clock and oversamples the externally supplied audio_sck / audio_lrck / audio_sdout lines.
- Feeds captured stereo samples to downstream processing (ADC path, loopback checking).

---
 rtl/serial_to_parallel.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/serial_to_parallel.sv
// -----------------------------------------------------------------------------
// serial_to_parallel
//
// Receive side of the audio serial link. The block samples audio_sck,
// audio_lrck and audio_sdout on the system clock and turns each 32-bit frame
// into one stereo sample pair. A frame is 16 left bits followed by 16 right
// bits, MSB first. A frame starts on the falling edge of lrck, and data is
// sampled on the rising edge of sck.
//
// Ports
//   clk              system clock; must run at least 4x audio_sck
//   rst_n            asynchronous active-low reset
//   audio_sck        serial bit clock; data is sampled on its rising edge
//   audio_lrck       frame clock; its falling edge starts a frame
//   audio_sdout      serial data, MSB first, left word then right word
//   audio_out_left   last complete left sample
//   audio_out_right  last complete right sample
//   sample_valid     one-clk pulse when audio_out_left/right update
//   frame_err        one-clk pulse when a frame ends with a bit count other
//                    than FRAME_BITS
// -----------------------------------------------------------------------------
module serial_to_parallel #(
  parameter int SYNC_STAGES = 2,   // legal range 2..4
  parameter int FRAME_BITS  = 32   // fixed at 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        audio_sck,
  input  logic        audio_lrck,
  input  logic        audio_sdout,
  output logic [15:0] audio_out_left,
  output logic [15:0] audio_out_right,
  output logic        sample_valid,
  output logic        frame_err
);

  localparam int          HALF     = FRAME_BITS / 2;
  localparam logic [5:0]  CNT_FULL = 6'(FRAME_BITS);
  // The counter stops one past a full frame, so an over-length frame can be
  // told apart from an exact one without wrapping.
  localparam logic [5:0]  CNT_SAT  = 6'(FRAME_BITS + 1);

  typedef enum logic {
    SYNC_WAIT,
    RECV
  } state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sck_sync, lrck_sync, sd_sync;
  logic                    sck_d, lrck_d;
  logic                    sck_rise_q, lrck_fall_q, sd_q;
  logic [FRAME_BITS-1:0]   shift_reg;
  logic [5:0]              bit_cnt;

  logic sck_s, lrck_s, sd_s;
  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign lrck_s = lrck_sync[SYNC_STAGES-1];
  assign sd_s   = sd_sync[SYNC_STAGES-1];

  // Synchroniser chains, edge-detect delay flops and a registered strobe
  // stage. sd goes through the same depth as sck, so the bit captured on a
  // strobe is the level that was on the pin when sck rose.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync    <= '0;
      lrck_sync   <= '0;
      sd_sync     <= '0;
      sck_d       <= 1'b0;
      lrck_d      <= 1'b0;
      sck_rise_q  <= 1'b0;
      lrck_fall_q <= 1'b0;
      sd_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop here sample the value
      // from before this edge. Blocking assignments would let a pin change
      // run through the whole chain in a single clock.
      sck_sync    <= {sck_sync[SYNC_STAGES-2:0],  audio_sck};
      lrck_sync   <= {lrck_sync[SYNC_STAGES-2:0], audio_lrck};
      sd_sync     <= {sd_sync[SYNC_STAGES-2:0],   audio_sdout};
      sck_d       <= sck_s;
      lrck_d      <= lrck_s;
      sck_rise_q  <= sck_s & ~sck_d;
      lrck_fall_q <= ~lrck_s & lrck_d;
      sd_q        <= sd_s;
    end
  end

  // Frame state machine. A frame boundary is always handled before a bit
  // strobe that arrives in the same clock. The boundary closes the old frame,
  // and the bit then opens the new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= SYNC_WAIT;
      shift_reg       <= '0;
      bit_cnt         <= '0;
      audio_out_left  <= '0;
      audio_out_right <= '0;
      sample_valid    <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      // NOTE: the pulses default low at the top of the block. Each branch
      // below only raises the pulse it needs, so the pulses can never stay
      // high for a second clock.
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;

      case (state)
        SYNC_WAIT: begin
          // Frame alignment is unknown until the first lrck fall. Any bits
          // that arrive before it are ignored.
          if (lrck_fall_q) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            state     <= RECV;
          end
        end

        RECV: begin
          if (lrck_fall_q) begin
            if (bit_cnt == CNT_FULL) begin
              audio_out_left  <= shift_reg[FRAME_BITS-1:HALF];
              audio_out_right <= shift_reg[HALF-1:0];
              sample_valid    <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            if (sck_rise_q) begin
              bit_cnt   <= 6'd1;
              shift_reg <= {{(FRAME_BITS-1){1'b0}}, sd_q};
            end else begin
              bit_cnt   <= '0;
              shift_reg <= '0;
            end
          end else if (sck_rise_q) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], sd_q};
            if (bit_cnt != CNT_SAT) begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
        end

        default: state <= SYNC_WAIT;
      endcase
    end
  end

endmodule
